// File: rtl/ripple_carry_adder4_pkg.sv
// Shared configuration for the ripple-carry adder slice.
package ripple_carry_adder4_pkg;

   localparam int unsigned DEFAULT_WIDTH = 4;
   localparam int unsigned MAX_WIDTH     = 64;

endpackage

// File: rtl/ripple_carry_adder4_if.sv
// Operand/result bundle for the ripple-carry adder; master drives operands, slave returns results.
interface ripple_carry_adder4_if
   import ripple_carry_adder4_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             c;
   logic [WIDTH-1:0] sum;
   logic             carry;

   modport master (
      output a,
      output b,
      output c,
      input  sum,
      input  carry
   );

   modport slave (
      input  a,
      input  b,
      input  c,
      output sum,
      output carry
   );

endinterface

// File: rtl/ripple_carry_adder4_full_adder.sv
// Single-bit full adder; one link of the carry ripple chain.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   logic p;

   assign p    = a ^ b;
   assign s    = p ^ cin;
   assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder4.sv
// Parameterised ripple-carry adder with registered sum/carry; one-cycle latency, loads every cycle.
module ripple_carry_adder4
   import ripple_carry_adder4_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   ripple_carry_adder4_if.slave    bus
);

   logic [WIDTH:0]   cy;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;

   assign cy[0] = bus.c;

   // Carry vector is one bit wider than the operands; its top bit is the carry-out.
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      full_adder u_fa (
         .a    (bus.a[i]),
         .b    (bus.b[i]),
         .cin  (cy[i]),
         .s    (s[i]),
         .cout (cy[i+1])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q   <= '0;
         carry_q <= 1'b0;
      end else begin
         sum_q   <= s;
         carry_q <= cy[WIDTH];
      end
   end

   assign bus.sum   = sum_q;
   assign bus.carry = carry_q;

endmodule

// File: tb/tb_ripple_carry_adder4.sv
// Self-checking bench: directed corners, exhaustive sweep with mid-stream reset, random tail.
module tb_ripple_carry_adder4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   ripple_carry_adder4_if #(.WIDTH(4)) bus ();

   ripple_carry_adder4 #(.WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input string tag, input logic r, input logic [3:0] av,
                       input logic [3:0] bv, input logic cv);
      int unsigned total;
      logic [3:0]  exp_sum;
      logic        exp_carry;
      rst   = r;
      bus.a = av;
      bus.b = bv;
      bus.c = cv;
      @(posedge clk);
      #1;
      total     = r ? 0 : int'(av) + int'(bv) + int'(cv);
      exp_sum   = 4'(total % 16);
      exp_carry = ((total / 16) != 0);
      checks++;
      assert (bus.sum === exp_sum) else begin
         errors++;
         $error("FAIL %s sum got %b exp %b (a=%b b=%b c=%b rst=%b)",
                tag, bus.sum, exp_sum, av, bv, cv, r);
      end
      checks++;
      assert (bus.carry === exp_carry) else begin
         errors++;
         $error("FAIL %s carry got %b exp %b (a=%b b=%b c=%b rst=%b)",
                tag, bus.carry, exp_carry, av, bv, cv, r);
      end
   endtask

   initial begin
      logic [8:0] v;
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      bus.a  = '0;
      bus.b  = '0;
      bus.c  = 1'b0;

      step("reset",      1'b1, 4'b1111, 4'b1111, 1'b1);
      step("zero",       1'b0, 4'b0000, 4'b0000, 1'b0);
      step("no_carry",   1'b0, 4'b0011, 4'b0101, 1'b0);
      step("wrap",       1'b0, 4'b1111, 4'b0001, 1'b0);
      step("cin_ripple", 1'b0, 4'b1010, 4'b0101, 1'b1);
      step("maximum",    1'b0, 4'b1111, 4'b1111, 1'b1);
      step("reset_prio", 1'b1, 4'b1111, 4'b1111, 1'b1);
      step("resume",     1'b0, 4'b1001, 4'b0110, 1'b1);

      for (int i = 0; i < 512; i++) begin
         v = 9'(i);
         step((i == 300) ? "exh_rst" : "exh", i == 300, v[8:5], v[4:1], v[0]);
      end

      for (int i = 0; i < 64; i++) begin
         step("rand", $urandom_range(0, 15) == 0, 4'($urandom), 4'($urandom),
              1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout sim ran past limit");
      $fatal(1, "timeout");
   end

endmodule
